// File: rtl/dda_frame_tx_if.sv
// Bundles the DDA-state inputs and the UART byte handshake of dda_frame_tx.
// master: the frame transmitter; slave: the DDA/UART side driving it.
interface dda_frame_tx_if #(
    parameter int N = 16
);
    logic         en;
    logic         step;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] z;
    logic         uart_is_transmitting;
    logic         uart_transmit;
    logic [7:0]   uart_tx_byte;
    logic         busy;
    logic [7:0]   frames_dropped;

    modport master (
        input  en, step, x, y, z, uart_is_transmitting,
        output uart_transmit, uart_tx_byte, busy, frames_dropped
    );

    modport slave (
        output en, step, x, y, z, uart_is_transmitting,
        input  uart_transmit, uart_tx_byte, busy, frames_dropped
    );
endinterface

// File: rtl/dda_frame_tx.sv
// Decimates DDA steps, snapshots (x, y, z) and sends it as a checksummed UART frame.
// Define DDA_FRAME_SEQ_EN to insert a rolling sequence byte after the sync byte.
//
// state      | meaning
// IDLE       | no frame in progress, waiting for a decimation trigger
// SEND       | uart_transmit high for one cycle with the current byte
// WAIT_START | waiting for the UART to report it is busy
// WAIT_DONE  | waiting for the UART to finish; then next byte or end of frame
module dda_frame_tx #(
    parameter int         N         = 16,
    parameter int         DECIM     = 256,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input logic            clk,
    input logic            rst,
    dda_frame_tx_if.master bus
);

`ifdef DDA_FRAME_SEQ_EN
    localparam logic [3:0] HDR_IDX = 4'd2;
`else
    localparam logic [3:0] HDR_IDX = 4'd1;
`endif
    localparam logic [3:0]  LAST_IDX = HDR_IDX + 4'd6;
    localparam logic [15:0] DECIM_TC = 16'(DECIM - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [3:0]   idx;
    logic [3:0]   idx_nx;
    logic [3:0]   pidx;
    logic         transmit_nx;
    logic         busy_nx;
    logic [7:0]   next_byte;
    logic [7:0]   chk;
    logic [15:0]  dec_cnt;
    logic         accept;
    logic         trigger;
    logic [N-1:0] snap_x;
    logic [N-1:0] snap_y;
    logic [N-1:0] snap_z;
`ifdef DDA_FRAME_SEQ_EN
    logic [7:0]   seq;
`endif

    assign accept  = bus.en & bus.step;
    assign trigger = accept && (dec_cnt == DECIM_TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt <= '0;
        end else if (accept) begin
            dec_cnt <= trigger ? 16'd0 : dec_cnt + 16'd1;
        end
    end

    // Snapshot only when a frame actually starts; dropped triggers leave it alone.
    always_ff @(posedge clk) begin
        if (!rst && trigger && state == IDLE) begin
            snap_x <= bus.x;
            snap_y <= bus.y;
            snap_z <= bus.z;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.frames_dropped <= '0;
        end else if (trigger && state != IDLE && bus.frames_dropped != 8'hFF) begin
            bus.frames_dropped <= bus.frames_dropped + 8'd1;
        end
    end

`ifdef DDA_FRAME_SEQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            seq <= '0;
        end else if (state == WAIT_DONE && !bus.uart_is_transmitting && idx == LAST_IDX) begin
            seq <= seq + 8'd1;
        end
    end
`endif

    always_comb begin
        chk = snap_x[15:8] ^ snap_x[7:0] ^ snap_y[15:8] ^ snap_y[7:0] ^ snap_z[15:8] ^ snap_z[7:0];
`ifdef DDA_FRAME_SEQ_EN
        chk = chk ^ seq;
`endif
    end

    // Byte selected by the index being loaded; header indices wrap pidx into the default arm.
    always_comb begin
        pidx      = idx_nx - HDR_IDX;
        next_byte = SYNC_BYTE;
        if (idx_nx != 4'd0) begin
            case (pidx)
                4'd0:    next_byte = snap_x[15:8];
                4'd1:    next_byte = snap_x[7:0];
                4'd2:    next_byte = snap_y[15:8];
                4'd3:    next_byte = snap_y[7:0];
                4'd4:    next_byte = snap_z[15:8];
                4'd5:    next_byte = snap_z[7:0];
                4'd6:    next_byte = chk;
`ifdef DDA_FRAME_SEQ_EN
                default: next_byte = seq;
`else
                default: next_byte = SYNC_BYTE;
`endif
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        transmit_nx = 1'b0;
        busy_nx     = bus.busy;
        unique case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (trigger) begin
                    idx_nx      = 4'd0;
                    transmit_nx = 1'b1;
                    busy_nx     = 1'b1;
                    state_nx    = SEND;
                end
            end
            SEND: begin
                state_nx = WAIT_START;
            end
            WAIT_START: begin
                if (bus.uart_is_transmitting) begin
                    state_nx = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.uart_is_transmitting) begin
                    if (idx == LAST_IDX) begin
                        idx_nx   = 4'd0;
                        busy_nx  = 1'b0;
                        state_nx = IDLE;
                    end else begin
                        idx_nx      = idx + 4'd1;
                        transmit_nx = 1'b1;
                        state_nx    = SEND;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            idx               <= '0;
            bus.uart_transmit <= 1'b0;
            bus.uart_tx_byte  <= 8'h00;
            bus.busy          <= 1'b0;
        end else begin
            state             <= state_nx;
            idx               <= idx_nx;
            bus.uart_transmit <= transmit_nx;
            bus.busy          <= busy_nx;
            if (transmit_nx) begin
                bus.uart_tx_byte <= next_byte;
            end
        end
    end

endmodule
